// File: rtl/systolic_n_body_feeder.sv
// systolic_n_body_feeder
//
// Transmit side of the systolic n-body array. A local table holds the
// position (q) and mass (m) of every body. After a start, the block runs
// one row-block pass per group of ARRAY_DIM bodies. In each pass the row
// lanes carry that group's bodies and stay fixed. The column lanes stream
// the whole table with a diagonal skew, so lane k lags lane 0 by k cycles.
// Each pass ends with DRAIN_CYC idle cycles so that accumulations can leave
// the array.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   load_valid/idx/q/m    table write port (accepted only while idle)
//   load_err              one-cycle pulse after a rejected load
//   start                 begin a full sweep (honoured only while idle)
//   array_ready           low freezes the sweep (STREAM/DRAIN only)
//   busy                  high from STREAM entry until DONE exits
//   pass_idx              current row block
//   pass_done             pulse on the last drain cycle of each pass
//   done                  pulse when the sweep completes
//   row_q/m/valid[k]      row-lane data
//   col_q/m/valid[k]      column-lane data
module systolic_n_body_feeder #(
  parameter int N_BODIES  = 4,
  parameter int ARRAY_DIM = 2,
  parameter int DRAIN_CYC = 3,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  input  real              load_q,
  input  real              load_m,
  output logic             load_err,
  input  logic             start,
  input  logic             array_ready,
  output logic             busy,
  output logic [IDX_W-1:0] pass_idx,
  output logic             pass_done,
  output logic             done,
  output real              row_q     [ARRAY_DIM],
  output real              row_m     [ARRAY_DIM],
  output logic             row_valid [ARRAY_DIM],
  output real              col_q     [ARRAY_DIM],
  output real              col_m     [ARRAY_DIM],
  output logic             col_valid [ARRAY_DIM]
);

  localparam int BI_W = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;
  localparam int CW   = $clog2(N_BODIES + ARRAY_DIM);
  localparam int DW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [CW-1:0]    LAST_C = CW'(N_BODIES + ARRAY_DIM - 2);
  localparam logic [DW-1:0]    LAST_D = DW'(DRAIN_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_R = IDX_W'(N_BODIES / ARRAY_DIM - 1);
  localparam logic [IDX_W-1:0] N_IDX  = IDX_W'(N_BODIES);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    c;
  logic [DW-1:0]    d;
  logic [IDX_W-1:0] r;

  real tbl_q [N_BODIES];
  real tbl_m [N_BODIES];

  logic             load_ok;
  logic             emit;
  logic             new_pass;
  logic [CW-1:0]    emit_c;
  logic [IDX_W-1:0] emit_r;
  logic             lane_v  [ARRAY_DIM];
  logic [BI_W-1:0]  lane_ci [ARRAY_DIM];
  logic [BI_W-1:0]  lane_ri [ARRAY_DIM];

  assign pass_idx = r;

  // Decide whether the coming edge publishes a new lane slice, and for which
  // (pass, cycle). A publish happens at sweep start, on every unstalled
  // STREAM advance, and when a drain finishes into the next pass. Each
  // lane's window and table indices are derived here from that target.
  always_comb begin
    load_ok  = load_valid && (state == IDLE) && (load_idx < N_IDX);
    emit     = 1'b0;
    new_pass = 1'b0;
    emit_c   = '0;
    emit_r   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          emit     = 1'b1;
          new_pass = 1'b1;
        end
      end
      STREAM: begin
        if (array_ready && (c != LAST_C)) begin
          emit   = 1'b1;
          emit_c = c + 1'b1;
          emit_r = r;
        end
      end
      DRAIN: begin
        if (array_ready && (d == LAST_D) && (r != LAST_R)) begin
          emit     = 1'b1;
          new_pass = 1'b1;
          emit_r   = r + 1'b1;
        end
      end
      DONE: begin
      end
    endcase
    for (int k = 0; k < ARRAY_DIM; k++) begin
      lane_v[k]  = emit && (int'(emit_c) >= k) && (int'(emit_c) < N_BODIES + k);
      lane_ci[k] = BI_W'(int'(emit_c) - k);
      lane_ri[k] = BI_W'(int'(emit_r) * ARRAY_DIM + k);
    end
  end

  // Body table. A reset leaves it intact, so a sweep can be replayed
  // without reloading.
  always_ff @(posedge clk) begin
    if (rst_n && load_ok) begin
      tbl_q[load_idx[BI_W-1:0]] <= load_q;
      tbl_m[load_idx[BI_W-1:0]] <= load_m;
    end
  end

  // Sweep sequencer and registered lane outputs. A write that arrives with
  // start is forwarded into the first slice, so the sweep sees the new
  // value. With array_ready low in STREAM/DRAIN no branch below fires, so
  // every output holds. This includes a pass_done pulse that is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      c         <= '0;
      d         <= '0;
      r         <= '0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      done      <= 1'b0;
      load_err  <= 1'b0;
      for (int k = 0; k < ARRAY_DIM; k++) begin
        row_q[k]     <= 0.0;
        row_m[k]     <= 0.0;
        row_valid[k] <= 1'b0;
        col_q[k]     <= 0.0;
        col_m[k]     <= 0.0;
        col_valid[k] <= 1'b0;
      end
    end else begin
      load_err <= load_valid && !load_ok;

      if (emit) begin
        for (int k = 0; k < ARRAY_DIM; k++) begin
          row_valid[k] <= lane_v[k];
          col_valid[k] <= lane_v[k];
          if (lane_v[k]) begin
            col_q[k] <= (load_ok && (load_idx[BI_W-1:0] == lane_ci[k])) ? load_q : tbl_q[lane_ci[k]];
            col_m[k] <= (load_ok && (load_idx[BI_W-1:0] == lane_ci[k])) ? load_m : tbl_m[lane_ci[k]];
          end
          if (new_pass) begin
            row_q[k] <= (load_ok && (load_idx[BI_W-1:0] == lane_ri[k])) ? load_q : tbl_q[lane_ri[k]];
            row_m[k] <= (load_ok && (load_idx[BI_W-1:0] == lane_ri[k])) ? load_m : tbl_m[lane_ri[k]];
          end
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
            c     <= '0;
            d     <= '0;
            r     <= '0;
          end
        end
        STREAM: begin
          if (array_ready) begin
            if (c == LAST_C) begin
              state     <= DRAIN;
              d         <= '0;
              pass_done <= (DRAIN_CYC == 1);
              for (int k = 0; k < ARRAY_DIM; k++) begin
                row_valid[k] <= 1'b0;
                col_valid[k] <= 1'b0;
              end
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (array_ready) begin
            if (d == LAST_D) begin
              pass_done <= 1'b0;
              if (r == LAST_R) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= STREAM;
                r     <= r + 1'b1;
                c     <= '0;
              end
            end else begin
              d         <= d + 1'b1;
              pass_done <= ((d + 1'b1) == LAST_D);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_n_body_feeder.sv
// Testbench for systolic_n_body_feeder. A sweep-level reference model
// tracks the sweep as a step number (pass * cycles-per-pass + phase) and
// derives every output from that step and the model body table. Each
// scenario task compares the DUT against the model every cycle and adds
// its own spot checks on the expected event timing.
module tb_systolic_n_body_feeder;

  localparam int NB = 4;
  localparam int D  = 2;
  localparam int DC = 3;
  localparam int IW = 3;
  localparam int PASS_CYC = NB + D - 1 + DC;
  localparam int SWEEP    = (NB / D) * PASS_CYC;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pass_done;
    logic [IW-1:0] pass_idx;
    logic          load_err;
    logic [D-1:0]  row_valid;
    logic [D-1:0]  col_valid;
    logic [D-1:0][63:0] row_q;
    logic [D-1:0][63:0] row_m;
    logic [D-1:0][63:0] col_q;
    logic [D-1:0][63:0] col_m;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n, load_valid, start, array_ready;
  logic [IW-1:0] load_idx;
  real load_q, load_m;
  logic load_err, busy, pass_done, done;
  logic [IW-1:0] pass_idx;
  real  row_q [D];
  real  row_m [D];
  logic row_valid [D];
  real  col_q [D];
  real  col_m [D];
  logic col_valid [D];

  int checks = 0;
  int failures = 0;

  real  body_q [NB];
  real  body_m [NB];
  bit   m_active;
  int   m_step;
  int   m_pass;
  logic e_load_err;
  real  e_row_q [D];
  real  e_row_m [D];
  real  e_col_q [D];
  real  e_col_m [D];
  snap_t exp_s;
  snap_t act;

  systolic_n_body_feeder #(.N_BODIES(NB), .ARRAY_DIM(D), .DRAIN_CYC(DC), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_idx(load_idx), .load_q(load_q), .load_m(load_m),
    .load_err(load_err), .start(start), .array_ready(array_ready),
    .busy(busy), .pass_idx(pass_idx), .pass_done(pass_done), .done(done),
    .row_q(row_q), .row_m(row_m), .row_valid(row_valid),
    .col_q(col_q), .col_m(col_m), .col_valid(col_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Advance the reference model across the coming rising edge, using the
  // inputs as they are currently driven.
  task automatic model_edge();
    bit accepted;
    int phase;
    if (!rst_n) begin
      m_active   = 1'b0;
      m_step     = 0;
      m_pass     = 0;
      e_load_err = 1'b0;
      for (int k = 0; k < D; k++) begin
        e_row_q[k] = 0.0; e_row_m[k] = 0.0; e_col_q[k] = 0.0; e_col_m[k] = 0.0;
      end
    end else begin
      accepted   = load_valid && !m_active && (int'(load_idx) < NB);
      e_load_err = load_valid && !accepted;
      if (accepted) begin
        body_q[int'(load_idx)] = load_q;
        body_m[int'(load_idx)] = load_m;
      end
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_step   = 0;
          m_pass   = 0;
        end
      end else if (m_step == SWEEP) begin
        m_active = 1'b0;
      end else if (array_ready) begin
        m_step++;
      end
      if (m_active && m_step < SWEEP) begin
        phase  = m_step % PASS_CYC;
        m_pass = m_step / PASS_CYC;
        for (int k = 0; k < D; k++) begin
          e_row_q[k] = body_q[m_pass * D + k];
          e_row_m[k] = body_m[m_pass * D + k];
          if (phase >= k && phase < NB + k) begin
            e_col_q[k] = body_q[phase - k];
            e_col_m[k] = body_m[phase - k];
          end
        end
      end
    end
    phase = m_step % PASS_CYC;
    exp_s.busy      = m_active;
    exp_s.done      = m_active && (m_step == SWEEP);
    exp_s.pass_done = m_active && (m_step < SWEEP) && (phase == PASS_CYC - 1);
    exp_s.pass_idx  = IW'(m_pass);
    exp_s.load_err  = e_load_err;
    for (int k = 0; k < D; k++) begin
      exp_s.row_valid[k] = m_active && (m_step < SWEEP) && (phase >= k) && (phase < NB + k);
      exp_s.col_valid[k] = exp_s.row_valid[k];
      exp_s.row_q[k] = $realtobits(e_row_q[k]);
      exp_s.row_m[k] = $realtobits(e_row_m[k]);
      exp_s.col_q[k] = $realtobits(e_col_q[k]);
      exp_s.col_m[k] = $realtobits(e_col_m[k]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  function automatic snap_t observe();
    snap_t s;
    s.busy      = busy;
    s.done      = done;
    s.pass_done = pass_done;
    s.pass_idx  = pass_idx;
    s.load_err  = load_err;
    for (int k = 0; k < D; k++) begin
      s.row_valid[k] = row_valid[k];
      s.col_valid[k] = col_valid[k];
      s.row_q[k] = $realtobits(row_q[k]);
      s.row_m[k] = $realtobits(row_m[k]);
      s.col_q[k] = $realtobits(col_q[k]);
      s.col_m[k] = $realtobits(col_m[k]);
    end
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("busy=%0b done=%0b pd=%0b pass=%0d lerr=%0b rv=%b cv=%b rq=%0.3f/%0.3f rm=%0.3f/%0.3f cq=%0.3f/%0.3f cm=%0.3f/%0.3f",
      s.busy, s.done, s.pass_done, s.pass_idx, s.load_err, s.row_valid, s.col_valid,
      $bitstoreal(s.row_q[0]), $bitstoreal(s.row_q[1]), $bitstoreal(s.row_m[0]), $bitstoreal(s.row_m[1]),
      $bitstoreal(s.col_q[0]), $bitstoreal(s.col_q[1]), $bitstoreal(s.col_m[0]), $bitstoreal(s.col_m[1]));
  endfunction

  function automatic real rnd_real();
    return real'($urandom_range(0, 4000)) / 16.0 - 125.0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; array_ready = 1'b1; load_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t == 2) begin rst_n = 1'b1; start = 1'b0; end
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL reset t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
    end
  endtask

  task automatic test_nominal();
    real nq [NB];
    int  pd_t [$];
    logic prev_pd;
    int  done_t;
    nq = '{-2.0, -1.0, 1.0, 2.0};
    for (int i = 0; i < NB; i++) begin
      load_valid = 1'b1; load_idx = IW'(i); load_q = nq[i]; load_m = 1.0;
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL nominal_load i=%0d got{%s} want{%s}", i, fmt(act), fmt(exp_s));
      end
    end
    load_valid = 1'b0;
    prev_pd = 1'b0;
    done_t = -1;
    for (int t = 1; t <= 19; t++) begin
      start = (t == 1);
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL nominal t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
      if (act.pass_done && !prev_pd) pd_t.push_back(t);
      prev_pd = act.pass_done;
      if (act.done === 1'b1) done_t = t;
      if (t <= 4) begin
        checks++;
        if ($realtobits(col_q[0]) !== $realtobits(nq[t-1])) begin
          failures++;
          $display("[TB] FAIL nominal_col0 t=%0d got=%0.3f want=%0.3f", t, col_q[0], nq[t-1]);
        end
      end
      if (t >= 2 && t <= 5) begin
        checks++;
        if ($realtobits(col_q[1]) !== $realtobits(nq[t-2])) begin
          failures++;
          $display("[TB] FAIL nominal_col1 t=%0d got=%0.3f want=%0.3f", t, col_q[1], nq[t-2]);
        end
      end
      if (t == 1 || t == 9) begin
        checks++;
        if ($realtobits(row_q[0]) !== $realtobits(nq[(t/9)*2]) || $realtobits(row_q[1]) !== $realtobits(nq[(t/9)*2+1])) begin
          failures++;
          $display("[TB] FAIL nominal_row t=%0d got=%0.3f/%0.3f want=%0.3f/%0.3f", t, row_q[0], row_q[1], nq[(t/9)*2], nq[(t/9)*2+1]);
        end
      end
      if (t == 18) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL nominal_busy_low got=%0b want=0", busy);
        end
      end
    end
    checks++;
    if (pd_t.size() != 2 || pd_t[0] != 8 || pd_t[1] != 16) begin
      failures++;
      $display("[TB] FAIL nominal_pass_done_cycles got=%p want='{8,16}", pd_t);
    end
    checks++;
    if (done_t != 17) begin
      failures++;
      $display("[TB] FAIL nominal_done_cycle got=%0d want=17", done_t);
    end
  endtask

  task automatic test_stall();
    int done_t;
    done_t = -1;
    for (int t = 1; t <= 22; t++) begin
      start = (t == 1);
      array_ready = !(t >= 4 && t <= 6);
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL stall t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
      if (act.done === 1'b1) done_t = t;
      if (t >= 3 && t <= 6) begin
        checks++;
        if ($realtobits(col_q[0]) !== $realtobits(1.0) || $realtobits(col_q[1]) !== $realtobits(-1.0) ||
            col_valid[0] !== 1'b1 || col_valid[1] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stall_hold t=%0d got=%0.3f/%0.3f v=%0b%0b want=1.000/-1.000 v=11", t, col_q[0], col_q[1], col_valid[0], col_valid[1]);
        end
      end
    end
    array_ready = 1'b1;
    checks++;
    if (done_t != 20) begin
      failures++;
      $display("[TB] FAIL stall_done_cycle got=%0d want=20", done_t);
    end
  endtask

  task automatic test_load_err();
    logic [IW-1:0] bad [2];
    bad[0] = IW'(4);
    bad[1] = IW'(7);
    for (int i = 0; i < 3; i++) begin
      load_valid = (i < 2);
      load_idx = (i < 2) ? bad[i] : '0;
      load_q = 99.0; load_m = 99.0;
      tick();
      act = observe();
      checks++;
      if (act !== exp_s || act.load_err !== (i < 2)) begin
        failures++;
        $display("[TB] FAIL load_err_idle i=%0d got{%s} want{%s}", i, fmt(act), fmt(exp_s));
      end
    end
    for (int t = 1; t <= 19; t++) begin
      start = (t == 1);
      load_valid = (t == 5 || t == 12);
      load_idx = (t == 5) ? IW'(0) : IW'(1);
      load_q = 55.0; load_m = 55.0;
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL load_err_busy t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
      if (t == 5 || t == 12) begin
        checks++;
        if (load_err !== 1'b1) begin
          failures++;
          $display("[TB] FAIL load_err_busy_pulse t=%0d got=%0b want=1", t, load_err);
        end
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_start_busy();
    int pd_rise, done_rise;
    logic prev_pd, prev_done;
    pd_rise = 0; done_rise = 0; prev_pd = 1'b0; prev_done = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      start = (t == 1 || t == 3 || t == 10 || t == 18);
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL start_busy t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
      if (act.pass_done && !prev_pd) pd_rise++;
      if (act.done && !prev_done) done_rise++;
      prev_pd = act.pass_done;
      prev_done = act.done;
    end
    start = 1'b0;
    checks++;
    if (pd_rise != 2 || done_rise != 1) begin
      failures++;
      $display("[TB] FAIL start_busy_events got pd=%0d done=%0d want pd=2 done=1", pd_rise, done_rise);
    end
  endtask

  task automatic test_reset_mid();
    int done_t;
    real nq [NB];
    nq = '{-2.0, -1.0, 1.0, 2.0};
    for (int t = 1; t <= 8; t++) begin
      start = (t == 1);
      rst_n = (t != 7);
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL reset_mid t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
    end
    done_t = -1;
    for (int t = 1; t <= 19; t++) begin
      start = (t == 1);
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL reset_replay t=%0d got{%s} want{%s}", t, fmt(act), fmt(exp_s));
      end
      if (act.done === 1'b1) done_t = t;
      if (t <= 4) begin
        checks++;
        if ($realtobits(col_q[0]) !== $realtobits(nq[t-1])) begin
          failures++;
          $display("[TB] FAIL reset_replay_col0 t=%0d got=%0.3f want=%0.3f", t, col_q[0], nq[t-1]);
        end
      end
    end
    checks++;
    if (done_t != 17) begin
      failures++;
      $display("[TB] FAIL reset_replay_done got=%0d want=17", done_t);
    end
  endtask

  task automatic test_random();
    for (int sw = 0; sw < 3; sw++) begin
      for (int i = 0; i < 6; i++) begin
        start = 1'b0;
        load_valid = 1'b1;
        load_idx = IW'($urandom_range(0, NB + 1));
        load_q = rnd_real(); load_m = rnd_real();
        array_ready = 1'($urandom_range(0, 1));
        tick();
        act = observe();
        checks++;
        if (act !== exp_s) begin
          failures++;
          $display("[TB] FAIL random_load sw=%0d i=%0d got{%s} want{%s}", sw, i, fmt(act), fmt(exp_s));
        end
      end
      load_valid = 1'b1;
      load_idx = IW'($urandom_range(0, NB - 1));
      load_q = rnd_real(); load_m = rnd_real();
      start = 1'b1;
      tick();
      act = observe();
      checks++;
      if (act !== exp_s) begin
        failures++;
        $display("[TB] FAIL random_start sw=%0d got{%s} want{%s}", sw, fmt(act), fmt(exp_s));
      end
      for (int t = 0; t < 80 && m_active; t++) begin
        array_ready = ($urandom_range(0, 3) != 0);
        load_valid = ($urandom_range(0, 7) == 0);
        load_idx = IW'($urandom_range(0, NB - 1));
        load_q = rnd_real(); load_m = rnd_real();
        start = ($urandom_range(0, 9) == 0);
        tick();
        act = observe();
        checks++;
        if (act !== exp_s) begin
          failures++;
          $display("[TB] FAIL random_sweep sw=%0d t=%0d got{%s} want{%s}", sw, t, fmt(act), fmt(exp_s));
        end
      end
      start = 1'b0; load_valid = 1'b0; array_ready = 1'b1;
      checks++;
      if (m_active || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL random_timeout sw=%0d busy=%0b want=0", sw, busy);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_idx = '0;
    load_q = 0.0; load_m = 0.0; array_ready = 1'b1;
    m_active = 1'b0; m_step = 0; m_pass = 0; e_load_err = 1'b0;
    for (int i = 0; i < NB; i++) begin body_q[i] = 0.0; body_m[i] = 0.0; end
    for (int k = 0; k < D; k++) begin
      e_row_q[k] = 0.0; e_row_m[k] = 0.0; e_col_q[k] = 0.0; e_col_m[k] = 0.0;
    end
    test_reset();
    test_nominal();
    test_stall();
    test_load_err();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
